// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered display data.
// Optional PWM dimming (i_bright port) is enabled by defining SEVSEG_DIM_EN.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_lz_en,
`ifdef SEVSEG_DIM_EN
    input  logic [3:0]              i_bright,
`endif
    output logic [6:0]              o_seg_out,
    output logic                    o_dp_out,
    output logic [NUM_DIGITS-1:0]   o_digit_en,
    output logic                    o_pending
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic          DP_OFF   = ACTIVE_LOW;
    localparam logic [6:0]    SEG_POL  = {7{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_pending;
    logic [CW-1:0]           r_div_cnt;
    logic [IW-1:0]           r_idx;
    logic [6:0]              r_seg_out;
    logic                    r_dp_out;
    logic [NUM_DIGITS-1:0]   r_digit_en;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_zero_above;
    logic [3:0]              w_nib;
    logic                    w_dp_cur;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_dim_ok;
    logic                    w_slot_on;
    logic [6:0]              w_seg_raw;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign w_slot_end  = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 is never blanked.
    always_comb begin
        w_zero_above = 1'b1;
        w_lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_disp_val[4*i +: 4] == 4'h0);
            w_lz_mask[i] = w_zero_above && (i != 0);
        end
    end

    always_comb begin
        w_nib    = 4'h0;
        w_dp_cur = 1'b0;
        w_blank  = 1'b0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_onehot[i] = (r_idx == IW'(i));
            if (r_idx == IW'(i)) begin
                w_nib    = r_disp_val[4*i +: 4];
                w_dp_cur = r_disp_dp[i];
                w_blank  = i_lz_en && w_lz_mask[i];
            end
        end
    end

`ifdef SEVSEG_DIM_EN
    localparam int SLICE = CLK_DIV / 16;
    logic [31:0] w_dim_limit;
    assign w_dim_limit = (32'(i_bright) + 32'd1) * 32'(SLICE);
    assign w_dim_ok    = (32'(r_div_cnt) < w_dim_limit);
`else
    assign w_dim_ok = 1'b1;
`endif

    assign w_slot_on = (r_div_cnt >= GUARD_C) && w_dim_ok;
    assign w_seg_raw = w_blank ? 7'h00 : seg_decode(w_nib);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Commit reads the pre-edge shadow, so a load on the commit edge waits for the next frame.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_frame_end && r_pending) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
                r_pending  <= 1'b0;
            end
            if (i_load) begin
                r_shadow_val <= i_value;
                r_shadow_dp  <= i_dp_in;
                r_pending    <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_seg_out  <= SEG_OFF;
            r_dp_out   <= DP_OFF;
            r_digit_en <= '0;
        end else begin
            r_seg_out  <= w_seg_raw ^ SEG_POL;
            r_dp_out   <= w_dp_cur ^ ACTIVE_LOW;
            r_digit_en <= w_slot_on ? w_onehot : '0;
        end
    end

    assign o_seg_out  = r_seg_out;
    assign o_dp_out   = r_dp_out;
    assign o_digit_en = r_digit_en;
    assign o_pending  = r_pending;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: time-based reference model plus directed literal checks.
module tb_seven_seg_scan_driver;

    localparam int N  = 4;
`ifdef SEVSEG_DIM_EN
    localparam int CD = 32;
`else
    localparam int CD = 8;
`endif
    localparam int G     = 1;
    localparam int FRAME = N * CD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
`ifdef SEVSEG_DIM_EN
    logic [3:0]  bright = 4'd15;
`endif
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        pending;

    seven_seg_scan_driver #(
        .NUM_DIGITS(N), .CLK_DIV(CD), .GUARD(G), .ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_load(load), .i_value(value),
        .i_dp_in(dp_in), .i_lz_en(lz_en),
`ifdef SEVSEG_DIM_EN
        .i_bright(bright),
`endif
        .o_seg_out(seg_out), .o_dp_out(dp_out), .o_digit_en(digit_en), .o_pending(pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position derived from the number of clock edges since reset release.
    logic [6:0]  SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          t;
    int          cur_frame = -1, cur_idx = -1, cur_pos = -1;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_ddp, m_sdp;
    logic        m_pend;
    bit          m_valid = 0;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_en;
    logic        e_pend;

    always @(posedge clk or posedge rst) begin
        bit         on, blank;
        logic [6:0] raw;
        if (rst) begin
            t = 0; m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 0;
            m_valid = 0; cur_frame = -1; cur_idx = -1; cur_pos = -1;
        end else begin
            cur_pos   = t % CD;
            cur_idx   = (t / CD) % N;
            cur_frame = t / FRAME;
            on = (cur_pos >= G);
`ifdef SEVSEG_DIM_EN
            on = on && (cur_pos < (int'(bright) + 1) * (CD / 16));
`endif
            e_en  = on ? 4'(1 << cur_idx) : 4'h0;
            blank = lz_en && (cur_idx != 0) && ((m_disp >> (4 * cur_idx)) == 16'h0);
            raw   = blank ? 7'h00 : SEG_TAB[m_disp[4*cur_idx +: 4]];
            e_seg = ~raw;
            e_dp  = ~m_ddp[cur_idx];
            if ((t % FRAME) == FRAME - 1 && m_pend) begin
                m_disp = m_shadow; m_ddp = m_sdp; m_pend = 0;
            end
            if (load) begin
                m_shadow = value; m_sdp = dp_in; m_pend = 1;
            end
            e_pend  = m_pend;
            t++;
            m_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (!rst && m_valid) begin
            chk("seg_out", 32'(seg_out), 32'(e_seg));
            chk("dp_out", 32'(dp_out), 32'(e_dp));
            chk("digit_en", 32'(digit_en), 32'(e_en));
            chk("pending", 32'(pending), 32'(e_pend));
        end
    end

    // Waits until the latest sample reflects scan position (frame, idx, pos).
    task automatic go_to(input int f, input int i, input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(cur_frame == f && cur_idx == i && cur_pos == p) && n < 5000);
        if (!(cur_frame == f && cur_idx == i && cur_pos == p)) begin
            n_checks++;
            $display("FAIL go_to timeout: at %0d/%0d/%0d expected %0d/%0d/%0d",
                     cur_frame, cur_idx, cur_pos, f, i, p);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg_out), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'h1);
        chk("rst_en", 32'(digit_en), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);

        rst = 1'b0;
        pulse_load(16'h12AF, 4'b0010);
        chk("pend_after_load", 32'(pending), 32'h1);
        go_to(0, 0, 3);
        chk("frame0_blank_disp", 32'(seg_out), 32'h40);
        go_to(1, 0, 0);
        chk("guard_en_low", 32'(digit_en), 32'h0);
        go_to(1, 0, 3);
        chk("d0_seg", 32'(seg_out), 32'h0E);
        chk("d0_en", 32'(digit_en), 32'h1);
        chk("d0_dp", 32'(dp_out), 32'h1);
        go_to(1, 1, 3);
        chk("d1_seg", 32'(seg_out), 32'h08);
        chk("d1_dp", 32'(dp_out), 32'h0);
        chk("d1_en", 32'(digit_en), 32'h2);
        go_to(1, 2, 3);
        chk("d2_seg", 32'(seg_out), 32'h24);
        chk("d2_en", 32'(digit_en), 32'h4);
        go_to(1, 3, 3);
        chk("d3_seg", 32'(seg_out), 32'h79);
        chk("d3_en", 32'(digit_en), 32'h8);

        go_to(1, 3, 4);
        lz_en = 1'b1;
        pulse_load(16'h0050, 4'b0000);
        go_to(2, 0, 4); chk("lz_d0", 32'(seg_out), 32'h40);
        go_to(2, 1, 4); chk("lz_d1", 32'(seg_out), 32'h12);
        go_to(2, 2, 4); chk("lz_d2", 32'(seg_out), 32'h7F);
        go_to(2, 3, 4); chk("lz_d3", 32'(seg_out), 32'h7F);
        go_to(2, 3, 5);
        pulse_load(16'h0000, 4'b0000);
        go_to(3, 0, 4); chk("lz0_d0", 32'(seg_out), 32'h40);
        go_to(3, 1, 4); chk("lz0_d1", 32'(seg_out), 32'h7F);
        go_to(3, 3, 4); chk("lz0_d3", 32'(seg_out), 32'h7F);
        go_to(3, 3, 5);
        lz_en = 1'b0;

        go_to(4, 1, 2);
        pulse_load(16'h1111, 4'b0000);
        go_to(4, 2, 4);
        chk("midframe_hold_seg", 32'(seg_out), 32'h40);
        chk("midframe_pend", 32'(pending), 32'h1);
        go_to(4, 3, 6); chk("pend_before_commit", 32'(pending), 32'h1);
        go_to(4, 3, 7); chk("pend_after_commit", 32'(pending), 32'h0);
        go_to(5, 0, 3); chk("new_frame_seg", 32'(seg_out), 32'h79);

        go_to(5, 1, 0);
        pulse_load(16'hAAAA, 4'b0000);
        go_to(5, 3, 6);
        pulse_load(16'hBBBB, 4'b1111);
        chk("commit_edge_pend", 32'(pending), 32'h1);
        go_to(6, 0, 3);
        chk("commit_edge_old", 32'(seg_out), 32'h08);
        chk("commit_edge_olddp", 32'(dp_out), 32'h1);
        go_to(6, 3, 7); chk("commit_edge_pend2", 32'(pending), 32'h0);
        go_to(7, 0, 3);
        chk("commit_edge_new", 32'(seg_out), 32'h03);
        chk("commit_edge_newdp", 32'(dp_out), 32'h0);

        go_to(7, 2, 5);
        chk("pre_rst_en", 32'(digit_en), 32'h4);
        rst = 1'b1;
        #1;
        chk("async_rst_en", 32'(digit_en), 32'h0);
        chk("async_rst_seg", 32'(seg_out), 32'h7F);
        chk("async_rst_dp", 32'(dp_out), 32'h1);
        chk("async_rst_pend", 32'(pending), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        go_to(0, 0, 0);
        chk("restart_en0", 32'(digit_en), 32'h0);
        chk("restart_seg", 32'(seg_out), 32'h40);
        go_to(0, 0, G);
        chk("restart_en1", 32'(digit_en), 32'h1);

        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            lz_en = 1'($urandom_range(0, 1));
            pulse_load(16'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) pulse_load(16'($urandom & 32'h00F0), 4'($urandom));
        end

`ifdef SEVSEG_DIM_EN
        begin
            int f;
            bright = 4'd3;
            f = cur_frame + 1;
            go_to(f, 0, 7); chk("dim3_on", 32'(digit_en), 32'h1);
            go_to(f, 0, 8); chk("dim3_off", 32'(digit_en), 32'h0);
            bright = 4'd15;
            go_to(f + 1, 0, 31); chk("dim15_on", 32'(digit_en), 32'h1);
        end
`endif

        repeat (FRAME) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised, time-multiplexed driver for a bank of common-anode/common-cathode seven-segment digits on the DE5-Net board. It replaces per-digit static decoding: a packed hex value and per-digit decimal points are loaded with a strobe, double-buffered, and scanned out one digit at a time with dead-time, optional leading-zero suppression and optional PWM dimming. It sits between the accelerator status/debug registers and the board display pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- CLK_DIV, 50000, clock cycles per digit slot (≥ GUARD+2; multiple of 16 when SEVSEG_DIM_EN)
- GUARD, 2, dead-time cycles at the start of each slot, all digits off
- ACTIVE_LOW, 1, 1: segment/dp pins active-low; 0: active-high (digit_en always active-high)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  capture value/dp_in into shadow register this cycle
- value  in  4*NUM_DIGITS  hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit
- lz_en  in  1  leading-zero suppression enable (sampled live)
- bright  in  4  brightness 0..15 (present only with SEVSEG_DIM_EN)
- seg_out  out  7  {g,f,e,d,c,b,a}, registered
- dp_out  out  1  decimal point, registered
- digit_en  out  NUM_DIGITS  one-hot digit select, registered
- pending  out  1  shadow holds data not yet shown

## Operation
- Registers: shadow (value+dp), display (value+dp), pending, div_cnt (0..CLK_DIV-1), idx (0..NUM_DIGITS-1).
- load=1: shadow <= {value,dp_in}, pending <= 1. Back-to-back loads: last wins.
- div_cnt increments every cycle; at CLK_DIV-1 wraps to 0 and idx increments; idx wraps NUM_DIGITS-1 -> 0.
- Commit: on the edge where idx wraps to 0, if pending: display <= shadow, pending <= 0. Display never changes mid-frame (tear-free).
- Load on the commit edge: commit takes the pre-edge shadow; new data goes to shadow and pending stays 1.
- Decode (hex 0..F): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,B=7C,C=39,D=5E,E=79,F=71 (active-high, bit0=a); inverted when ACTIVE_LOW.
- Leading-zero suppression (lz_en=1): digit i blanked (segments off, dp honoured) iff all nibbles i..NUM_DIGITS-1 are 0 and i≠0. Digit 0 always shown.
- Slot gating: digit_en = one-hot(idx) only when div_cnt ≥ GUARD (and dim gate, below); else all zero.
- Reset (any time, async): shadow, display, pending, div_cnt, idx = 0; digit_en = 0; seg_out, dp_out = off (7'h7F/1 if ACTIVE_LOW, else 0).

## Timing
- Outputs registered: seg_out/dp_out/digit_en reflect div_cnt/idx/display from the previous cycle (1-cycle latency).
- Frame period = NUM_DIGITS*CLK_DIV cycles.
- Load-to-display latency: until the next idx wrap, plus 1 output cycle; worst case one frame + 1 cycle.
- pending rises the cycle after load, falls the cycle after commit.
- First slot after reset release: digit 0, digit_en asserted at cycle GUARD+1.

## Configuration
- SEVSEG_DIM_EN defined: bright port present; slot split into 16 slices of CLK_DIV/16 cycles; digit_en additionally requires div_cnt < (bright+1)*(CLK_DIV/16). bright=15 equals undimmed; bright=0 gives 1/16 on-time (minus guard).
- Not defined: no bright port; digit_en on for the whole slot after GUARD.

## Test plan
- NUM_DIGITS=4, CLK_DIV=8, GUARD=1, ACTIVE_LOW=1: reset, load value=16'h12AF, dp_in=4'b0010 -> after the first wrap, slot 0 seg_out=7'h0E, slot 1 7'h08 dp_out=0, slot 2 7'h24, slot 3 7'h79; digit_en one-hot 0001..1000, low at div_cnt=0.
- lz_en=1, value=16'h0050 -> digits 3,2 segments 7'h7F; digit 1 7'h12, digit 0 7'h40; value=0 -> only digit 0 shows 7'h40.
- Load 16'h1111 mid-frame at idx=1 -> display unchanged until idx wraps to 0; pending 1 until then, 0 one cycle after.
- Load on the exact commit edge with shadow=16'hAAAA, new value=16'hBBBB -> frame shows AAAA, pending stays 1, next frame shows BBBB.
- Assert reset at idx=2, div_cnt=5 -> next sample: digit_en=0, seg_out=7'h7F, dp_out=1, pending=0; scan restarts at digit 0.
- SEVSEG_DIM_EN, CLK_DIV=32, GUARD=1, bright=3 -> digit_en high for div_cnt 1..7 (7 cycles) per slot; bright=15 -> div_cnt 1..31.
